// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, iterative FSM encoding and S-box tables.
// The inverse table is only compiled in when SUB_BYTES_INV_EN is defined.
package aes_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSub  = 2'd1,
    StHold = 2'd2
  } sub_fsm_e;

  // Element 0 is the most significant byte, so the table reads in natural order.
  localparam logic [0:255][7:0] SBOX_FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD_TBL[b];
  endfunction

`ifdef SUB_BYTES_INV_EN
  localparam logic [0:255][7:0] SBOX_INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f6648668981604a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV_TBL[b];
  endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lane. Inverse selection exists only with SUB_BYTES_INV_EN.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
`ifdef SUB_BYTES_INV_EN
  input  logic       inv_i,
`endif
  output logic [7:0] data_o
);

`ifdef SUB_BYTES_INV_EN
  assign data_o = inv_i ? sbox_inv(data_i) : sbox_fwd(data_i);
`else
  assign data_o = sbox_fwd(data_i);
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: LANES bytes per cycle, 16/LANES cycles per block.
// SUB_BYTES_INV_EN adds in_inv, which selects the inverse S-box for a whole block.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:STATE_W-1] in_data,
`ifdef SUB_BYTES_INV_EN
  input  logic               in_inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:STATE_W-1] out_data,
  output logic               busy
);

  localparam int unsigned N     = 16 / LANES;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : gen_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  sub_fsm_e           fsm_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [0:STATE_W-1] st_q;
  logic [0:STATE_W-1] st_sub;
  logic [7:0]         lane_in  [LANES];
  logic [7:0]         lane_out [LANES];

`ifdef SUB_BYTES_INV_EN
  logic inv_q;
`endif

  for (genvar l = 0; l < LANES; l++) begin : gen_lane
    assign lane_in[l] = st_q[BYTE_W * (int'(cnt_q) * LANES + l) +: BYTE_W];

    aes_sbox u_sbox (
      .data_i (lane_in[l]),
`ifdef SUB_BYTES_INV_EN
      .inv_i  (inv_q),
`endif
      .data_o (lane_out[l])
    );
  end

  // Only the bytes addressed by cnt_q change; everything else holds.
  always_comb begin
    st_sub = st_q;
    for (int l = 0; l < LANES; l++) begin
      st_sub[BYTE_W * (int'(cnt_q) * LANES + l) +: BYTE_W] = lane_out[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= StIdle;
      cnt_q <= '0;
      st_q  <= '0;
`ifdef SUB_BYTES_INV_EN
      inv_q <= 1'b0;
`endif
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (in_valid) begin
            st_q  <= in_data;
            cnt_q <= '0;
            fsm_q <= StSub;
`ifdef SUB_BYTES_INV_EN
            inv_q <= in_inv;
`endif
          end
        end
        StSub: begin
          st_q <= st_sub;
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            fsm_q <= StHold;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StHold: begin
          if (out_ready) begin
            fsm_q <= StIdle;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (fsm_q == StIdle) & ~rst;
  assign out_valid = (fsm_q == StHold);
  assign busy      = (fsm_q != StIdle);
  assign out_data  = st_q;

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative AES SubBytes stage that sits directly upstream of `shift_rows` in the round datapath. It accepts one 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES S-box instances. It then presents the substituted state, in unchanged byte order, to the `shift_rows` input. Area is traded against latency through the LANES parameter.

## Interface
- `LANES`, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error. `N = 16/LANES` cycles per block.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: upstream state present.
- `in_ready` output 1: block can accept a state.
- `in_data` input [0:127]: state. Byte i = bits [8i +: 8], column-major (byte = 4·col + row), byte 0 is the MSB.
- `out_valid` output 1: substituted state present.
- `out_ready` input 1: downstream accepts.
- `out_data` output [0:127]: substituted state, same byte ordering; feeds `shift_rows_in`.
- `busy` output 1: a block is in flight (SUB or HOLD).
- `in_inv` input 1: exists only with `SUB_BYTES_INV_EN` (see Configuration).

## Operation
- State register `st[0:127]`, byte counter `cnt` (width log2(N), minimum 1), FSM with states IDLE, SUB, HOLD.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid & in_ready` at an edge: `st <= in_data`, `cnt <= 0`, go to SUB.
- SUB:
  - At each edge, bytes `LANES·cnt … LANES·cnt+LANES-1` of `st` are replaced by `sbox(byte)`; all other bytes hold.
  - `cnt` increments.
  - When `cnt == N-1` at the edge, go to HOLD. Bytes are processed in ascending index order.
  - `in_data` and `in_valid` are ignored in this state.
- HOLD:
  - `out_valid = 1`.
  - On `out_ready`, go to IDLE.
  - `st` is frozen.
- Outputs:
  - `out_data = st` at all times.
  - `in_ready = (fsm == IDLE) & ~rst`.
  - `out_valid = (fsm == HOLD)`.
  - `busy = (fsm != IDLE)`.
- Reset: with `rst` high at an edge, fsm goes to IDLE, `cnt` to 0 and `st` to 128'h0. After reset, `out_valid = 0`, `busy = 0` and `out_data = 0`. `in_ready` is 0 while `rst` is high and 1 after release.
- Reset mid-operation (SUB or HOLD): the block is discarded and no output is produced. A handshake attempted in the same cycle as `rst` is ignored.
- No back-to-back bypass: `in_ready` is low throughout HOLD, even when `out_ready` is high.

## Timing
- Acceptance at edge E0. Substitution occurs on edges E1…EN. `out_valid` is high starting the cycle after EN.
  - Latency is N cycles from acceptance to `out_valid`; with LANES=4 this is 4 cycles.
- With `out_ready` held high, the output handshake is at E(N+1) and the next acceptance is at E(N+2).
  - Minimum period is N+2 cycles per block.
- `out_data` is stable while `out_valid & ~out_ready`, for any stall length.
- The S-box path is combinational within one cycle. No output is driven combinationally from `in_data`.

## Configuration
- `SUB_BYTES_INV_EN` defined:
  - Adds the `in_inv` port, sampled at acceptance into a mode flop.
  - When the mode flop is 1, every lane uses the inverse S-box for that whole block; the decryption path uses this.
  - The mode flop resets to 0.
- `SUB_BYTES_INV_EN` undefined: no `in_inv` port, forward S-box only, and no inverse table is synthesized.

## Structure
- Shared package `aes_pkg`:
  - State width (128) and byte width (8).
  - FSM state encodings.
  - Forward and inverse S-box functions, with tables defined once.
- Sub-module `aes_sbox`:
  - Combinational, 8-bit in, 8-bit out.
  - Has an `inv` input only under `SUB_BYTES_INV_EN`.
  - Instantiated LANES times.

## Test plan
- FIPS-197 Appendix B, LANES=4: input 193de3bea0f4e22b9ac68d2ae9f84808 → `out_data` d42711aee0bf98f1b8b45de51e415230, with `out_valid` rising exactly 4 cycles after acceptance.
- All-zero input with LANES=1 → 16× 0x63 after 16 cycles. With LANES=16 the same result appears after 1 cycle.
- Backpressure: hold `out_ready` low for 10 cycles in HOLD → `out_data` unchanged and `in_ready` stays 0; release → exactly one transfer, then back to IDLE.
- Streaming: three consecutive blocks with `in_valid` and `out_ready` held high → accepts spaced N+2 cycles apart, outputs in order and correct.
- Reset mid-SUB: assert `rst` one cycle after acceptance → next cycle `busy = 0`, `out_valid = 0`, `out_data = 0`, and no output transfer follows.
- `SUB_BYTES_INV_EN`: input 16× 0x63 with `in_inv = 1` → 128'h0. Input d42711ae… with `in_inv = 1` → 193de3be….
